l2_mem_responder: RTL
=====================

Name: l2_mem_responder

Overview:
- Backing-store responder on the L2 side of the L1-cache-to-L2 refill interface.
- Accepts single-word writes and 8-word line-refill reads issued by the L1 cache miss path.
- Read bursts are critical-word-first after a programmable latency. Storage is an internal word array.
- Used as the L2/main-memory model under the cache, and as the synthesizable on-chip L2 for small configurations.

Parameters:
- ADDR_W, 32, request address width (byte address).
- DATA_W, 32, data word width.
- DEPTH_WORDS, 4096, storage depth in words; power of two.
- RD_LATENCY, 4, cycles from request acceptance to first read word; legal range 1..15.
- BURST_LEN, 8, words per line refill; power of two; matches the cache line of 8 words.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- l2_mem_en  in  1  request strobe; sampled only when l2_mem_busy=0.
- l2_mem_wr_en  in  1  qualifies the request: 1=write, 0=read refill.
- l2_mem_access_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- l2_mem_wr_data  in  DATA_W  write data.
- l2_mem_rd_data  out  DATA_W  read word; valid only with l2_mem_rd_valid.
- l2_mem_rd_valid  out  1  one word per cycle during a burst.
- l2_mem_rd_last  out  1  high with the final word of a burst.
- l2_mem_busy  out  1  responder is not accepting requests.
- l2_mem_wr_ack  out  1  single-cycle pulse, one cycle after a write is accepted.
- l2_mem_err  out  1  address range error pulse (see Optional Feature).

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters cleared. Storage array is not cleared.
- Reset mid-burst: the burst is abandoned with no further valid beats and no rd_last.
- Accept: a request is accepted at an edge where l2_mem_en=1 and l2_mem_busy=0. While busy, l2_mem_en is ignored, not queued.
- Word index: widx = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are discarded, so addresses alias modulo the depth.
- Line base: widx with its low log2(BURST_LEN) bits cleared.
- Write (wr_en=1):
  - Array written at the accept edge.
  - l2_mem_wr_ack=1 for exactly the next cycle; busy stays 0.
  - Back-to-back writes are accepted every cycle.
  - A read accepted on the edge after a write returns the written data.
- Read (wr_en=0):
  - At the accept edge: latch the line base and start offset s = widx low bits; FSM to WAIT; busy=1 from the next cycle.
  - WAIT: latency counter runs; the first beat appears RD_LATENCY cycles after the accept edge. RD_LATENCY=1 means the first valid beat is on the cycle immediately after acceptance.
  - BURST: BURST_LEN consecutive valid cycles; beat k returns word base + ((s+k) mod BURST_LEN).
  - Wrap: the offset wraps within the line and never crosses into the next line (start offset 6 with BURST_LEN 8 gives offsets 6,7,0,1,2,3,4,5).
  - rd_last is high on beat BURST_LEN-1 only.
  - busy falls in the cycle after the last beat; a new request can be accepted at the edge ending that cycle.
- l2_mem_rd_data is 0 whenever rd_valid=0; no stale data is driven.
- States: IDLE -> WAIT (read accepted) -> BURST (latency expired) -> IDLE (last beat). Writes never leave IDLE.
- Array read is synchronous, one cycle; the pipeline is arranged so the latency above is exact.

Optional Feature:
- Macro: L2_RESP_ADDR_CHECK_EN.
- Defined: an accepted request with any address bit above log2(DEPTH_WORDS)+1 set, or with addr[1:0]!=0, pulses l2_mem_err for one cycle after acceptance.
  - Such a write is dropped: no array update, but wr_ack still pulses.
  - Such a read still runs its full burst with data forced to 0.
- Undefined: l2_mem_err is tied 0; addresses alias silently.

Decomposition:
- Package l2_mem_pkg holds:
  - FSM state enum (IDLE, WAIT, BURST).
  - Localparams derived from the parameters: word-index width and offset width.
  - A request struct {addr, wr_en, wr_data}.
- Sub-module l2_mem_array: single-port synchronous word RAM with write enable, shared with the cache memory model style. The FSM, counters, and wrap logic stay in the top module.

Test Plan:
- Write addr 0x0000_0044 data 0xDEAD_BEEF, then read 0x0000_0044 on the next edge -> wr_ack one cycle after the write. The read's first beat arrives 4 cycles after acceptance with data 0xDEAD_BEEF, followed by words at 0x48..0x5C, 0x40, with rd_last on the 8th beat.
- Preload words 0x40..0x5C with values 0..7; read 0x0000_0058 -> beats 6,7,0,1,2,3,4,5; busy high from acceptance+1 through the last beat.
- Assert l2_mem_en continuously with reads during a burst -> no second burst starts until busy drops; the next burst starts exactly 1 accept edge after busy falls.
- Assert rst on the 3rd beat of a burst -> rd_valid, rd_last and busy go 0 immediately. A read issued after reset returns correct data, showing the array was preserved.
- RD_LATENCY=1 build: read 0x0 -> first valid beat on the cycle right after acceptance; 8 beats; no gap cycles.
- L2_RESP_ADDR_CHECK_EN, DEPTH_WORDS=4096: write to 0x0001_0000 -> err pulse, array unchanged. Same build, read 0x0000_0002 -> err pulse plus 8 zero beats.

Source files
------------

// File: rtl/l2_mem_pkg.sv
// Shared types and derived widths for the L2 refill responder.
package l2_mem_pkg;

    localparam int L2_ADDR_W      = 32;
    localparam int L2_DATA_W      = 32;
    localparam int L2_DEPTH_WORDS = 4096;
    localparam int L2_BURST_LEN   = 8;
    localparam int L2_IDX_W       = $clog2(L2_DEPTH_WORDS);
    localparam int L2_OFF_W       = $clog2(L2_BURST_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } l2_state_e;

    typedef struct packed {
        logic [L2_ADDR_W-1:0] addr;
        logic                 wr_en;
        logic [L2_DATA_W-1:0] wr_data;
    } l2_req_t;

    function automatic int l2_idx_w(input int depth_words);
        return $clog2(depth_words);
    endfunction

    function automatic int l2_off_w(input int burst_len);
        return $clog2(burst_len);
    endfunction

endpackage

// File: rtl/l2_mem_array.sv
// Single-port synchronous word RAM, one-cycle registered read.
module l2_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/l2_mem_responder.sv
// L2 refill responder: single-word writes, critical-word-first line reads.
// Optional address range checking: define L2_RESP_ADDR_CHECK_EN.
module l2_mem_responder
    import l2_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 4096,
    parameter int RD_LATENCY  = 4,
    parameter int BURST_LEN   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              l2_mem_en,
    input  logic              l2_mem_wr_en,
    input  logic [ADDR_W-1:0] l2_mem_access_addr,
    input  logic [DATA_W-1:0] l2_mem_wr_data,
    output logic [DATA_W-1:0] l2_mem_rd_data,
    output logic              l2_mem_rd_valid,
    output logic              l2_mem_rd_last,
    output logic              l2_mem_busy,
    output logic              l2_mem_wr_ack,
    output logic              l2_mem_err
);

    localparam int IDX_W  = l2_idx_w(DEPTH_WORDS);
    localparam int OFF_W  = l2_off_w(BURST_LEN);
    localparam int LINE_W = IDX_W - OFF_W;

    localparam logic [3:0]       LAT_LAST  = 4'(RD_LATENCY - 1);
    localparam logic [OFF_W-1:0] BEAT_LAST = OFF_W'(BURST_LEN - 1);

    l2_state_e          r_state;
    l2_state_e          w_state_nxt;
    logic [3:0]         r_lat;
    logic [3:0]         w_lat_nxt;
    logic [OFF_W-1:0]   r_beat;
    logic [OFF_W-1:0]   w_beat_nxt;
    logic [OFF_W-1:0]   r_off;
    logic [OFF_W-1:0]   w_next_off;
    logic [LINE_W-1:0]  r_line;
    logic               r_bad;
    logic               r_wr_ack;
    logic               r_err;

    logic               w_accept;
    logic               w_bad;
    logic [IDX_W-1:0]   w_widx;
    logic               w_ram_we;
    logic [IDX_W-1:0]   w_ram_addr;
    logic [DATA_W-1:0]  w_ram_q;
    logic               w_valid;

    assign w_widx   = l2_mem_access_addr[IDX_W+1:2];
    assign w_accept = l2_mem_en & ~l2_mem_busy;

`ifdef L2_RESP_ADDR_CHECK_EN
    assign w_bad = ((l2_mem_access_addr >> (IDX_W + 2)) != '0)
                 | (l2_mem_access_addr[1:0] != 2'b00);
`else
    logic [ADDR_W-IDX_W-1:0] w_unused_addr;
    assign w_unused_addr = {l2_mem_access_addr[ADDR_W-1:IDX_W+2],
                            l2_mem_access_addr[1:0]};
    assign w_bad = 1'b0;
`endif

    // Offset of the beat after the one currently on the bus, wrapping in-line
    assign w_next_off = r_off + r_beat + OFF_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_lat_nxt   = r_lat;
        w_beat_nxt  = r_beat;
        w_ram_we    = 1'b0;
        w_ram_addr  = w_widx;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (l2_mem_wr_en) begin
                        w_ram_we = ~w_bad;
                    end else begin
                        w_lat_nxt   = 4'd1;
                        w_beat_nxt  = '0;
                        w_state_nxt = (RD_LATENCY == 1) ? BURST : WAIT;
                    end
                end
            end
            WAIT: begin
                w_ram_addr = {r_line, r_off};
                if (r_lat == LAT_LAST) begin
                    w_state_nxt = BURST;
                    w_beat_nxt  = '0;
                end else begin
                    w_lat_nxt = r_lat + 4'd1;
                end
            end
            BURST: begin
                w_ram_addr = {r_line, w_next_off};
                if (r_beat == BEAT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_beat_nxt = r_beat + OFF_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_lat    <= '0;
            r_beat   <= '0;
            r_off    <= '0;
            r_line   <= '0;
            r_bad    <= 1'b0;
            r_wr_ack <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_lat    <= w_lat_nxt;
            r_beat   <= w_beat_nxt;
            r_wr_ack <= w_accept & l2_mem_wr_en;
            r_err    <= w_accept & w_bad;
            if (w_accept && !l2_mem_wr_en) begin
                r_line <= w_widx[IDX_W-1:OFF_W];
                r_off  <= w_widx[OFF_W-1:0];
                r_bad  <= w_bad;
            end
        end
    end

    l2_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH_WORDS),
        .AW     (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (l2_mem_wr_data),
        .o_rdata (w_ram_q)
    );

    assign w_valid         = (r_state == BURST);
    assign l2_mem_rd_valid = w_valid;
    assign l2_mem_rd_last  = w_valid & (r_beat == BEAT_LAST);
    assign l2_mem_rd_data  = (w_valid & ~r_bad) ? w_ram_q : '0;
    assign l2_mem_busy     = (r_state != IDLE);
    assign l2_mem_wr_ack   = r_wr_ack;
    assign l2_mem_err      = r_err;

endmodule
